// File: rtl/iobus_initiator.sv
// Initiator end of the MicroBlaze MCS IO bus: valid/ready command in, single bus cycle, response out.
// Optional IOBUS_INITIATOR_ALIGN_CHECK_EN rejects misaligned/empty-byte-enable commands without a bus cycle.
module iobus_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_READ_DATA  = 32'hFFFF_FFFF
) (
    input  logic        io_clk,
    input  logic        io_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_be,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        io_addr_strobe,
    output logic        io_read_strobe,
    output logic        io_write_strobe,
    output logic [31:0] io_address,
    output logic [3:0]  io_byte_enable,
    output logic [31:0] io_write_data,
    input  logic [31:0] io_read_data,
    input  logic        io_ready
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_TO  = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          write_q, write_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          accept;
    logic          cmd_ok;

    always_ff @(posedge io_clk or negedge io_rst) begin
        if (!io_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

`ifdef IOBUS_INITIATOR_ALIGN_CHECK_EN
    assign cmd_ok = (cmd_addr[1:0] == 2'b00) && (cmd_be != 4'b0000);
`else
    assign cmd_ok = 1'b1;
`endif

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        write_d = write_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_ok) begin
                        addr_d  = cmd_addr;
                        be_d    = cmd_be;
                        wdata_d = cmd_wdata;
                        write_d = cmd_write;
                        cnt_d   = '0;
                        state_d = S_STROBE;
                    end else begin
                        // Rejected command answers without touching the bus
                        err_d   = 1'b1;
                        rdata_d = ERR_READ_DATA;
                        state_d = S_RESP;
                    end
                end
            end
            S_STROBE: begin
                if (io_ready) begin
                    err_d   = 1'b0;
                    rdata_d = write_q ? 32'h0 : io_read_data;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (io_ready) begin
                    err_d   = 1'b0;
                    rdata_d = write_q ? 32'h0 : io_read_data;
                    state_d = S_RESP;
                end else if (TIMEOUT_CYCLES != 0 && cnt_d == CNT_TO) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_READ_DATA;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready       = (state_q == S_IDLE) && io_rst;
    assign busy            = (state_q != S_IDLE);
    assign io_addr_strobe  = (state_q == S_STROBE);
    assign io_read_strobe  = io_addr_strobe && !write_q;
    assign io_write_strobe = io_addr_strobe && write_q;
    assign io_address      = addr_q;
    assign io_byte_enable  = be_q;
    assign io_write_data   = wdata_q;
    assign rsp_valid       = (state_q == S_RESP);
    assign rsp_rdata       = rdata_q;
    assign rsp_err         = err_q;

endmodule

// File: tb/tb_iobus_initiator.sv
// Directed self-checking bench for iobus_initiator (TIMEOUT_CYCLES=8).
// Each task drives one scenario and checks hand-computed values inline.
module tb_iobus_initiator;

    logic        io_clk;
    logic        io_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        io_addr_strobe;
    logic        io_read_strobe;
    logic        io_write_strobe;
    logic [31:0] io_address;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;
    logic        io_ready;

    int checks = 0;
    int errors = 0;
    int n_as = 0;
    int n_rs = 0;
    int n_ws = 0;
    int b_as;
    int b_rs;

    iobus_initiator #(
        .TIMEOUT_CYCLES(8),
        .ERR_READ_DATA(32'hFFFF_FFFF)
    ) dut (
        .io_clk(io_clk),
        .io_rst(io_rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_be(cmd_be),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .busy(busy),
        .io_addr_strobe(io_addr_strobe),
        .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe),
        .io_address(io_address),
        .io_byte_enable(io_byte_enable),
        .io_write_data(io_write_data),
        .io_read_data(io_read_data),
        .io_ready(io_ready)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    always @(posedge io_clk) begin
        if (io_addr_strobe)  n_as <= n_as + 1;
        if (io_read_strobe)  n_rs <= n_rs + 1;
        if (io_write_strobe) n_ws <= n_ws + 1;
    end

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_be    = be;
        cmd_wdata = d;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready got %b exp 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        io_rst = 1'b0;
        #12;
        checks++;
        if ({cmd_ready, busy, io_addr_strobe, io_read_strobe, io_write_strobe,
             rsp_valid, rsp_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b%b%b%b%b%b%b exp 0000000", cmd_ready, busy,
                     io_addr_strobe, io_read_strobe, io_write_strobe, rsp_valid, rsp_err);
        end
        checks++;
        if ({io_address, io_byte_enable, io_write_data, rsp_rdata} !== 100'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h exp 0", io_address, io_byte_enable,
                     io_write_data, rsp_rdata);
        end
        @(negedge io_clk);
        io_rst = 1'b1;
        tick();
        #4;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b exp 1", cmd_ready);
        end
    endtask

    task automatic test_read_comb();
        b_as = n_as;
        b_rs = n_rs;
        send_cmd(1'b0, 32'hC000_1000, 4'hF, 32'h0);
        io_ready = 1'b1;
        io_read_data = 32'h1234_5678;
        #4;
        checks++;
        if ({io_addr_strobe, io_read_strobe, io_write_strobe, rsp_valid} !== 4'b1100) begin
            errors++;
            $display("FAIL rd_strobe got %b%b%b%b exp 1100", io_addr_strobe, io_read_strobe,
                     io_write_strobe, rsp_valid);
        end
        checks++;
        if (io_address !== 32'hC000_1000) begin
            errors++;
            $display("FAIL rd_addr got %h exp c0001000", io_address);
        end
        tick();
        io_ready = 1'b0;
        io_read_data = 32'h0;
        #4;
        checks++;
        if ({rsp_valid, rsp_err, cmd_ready, busy} !== 4'b1001) begin
            errors++;
            $display("FAIL rd_resp_ctrl got %b%b%b%b exp 1001", rsp_valid, rsp_err,
                     cmd_ready, busy);
        end
        checks++;
        if (rsp_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd_rdata got %h exp 12345678", rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #4;
        checks++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL rd_idle got %b%b%b exp 010", rsp_valid, cmd_ready, busy);
        end
        checks++;
        if (n_as - b_as !== 1 || n_rs - b_rs !== 1) begin
            errors++;
            $display("FAIL rd_strobe_count got %0d/%0d exp 1/1", n_as - b_as, n_rs - b_rs);
        end
    endtask

    task automatic test_write_wait();
        send_cmd(1'b1, 32'hC000_0004, 4'b0011, 32'hA5A5_0F0F);
        for (int k = 0; k < 6; k++) begin
            if (k == 5) io_ready = 1'b1;
            #4;
            checks++;
            if ({io_address, io_byte_enable, io_write_data} !==
                {32'hC000_0004, 4'b0011, 32'hA5A5_0F0F}) begin
                errors++;
                $display("FAIL wr_hold[%0d] got %h %h %h", k, io_address, io_byte_enable,
                         io_write_data);
            end
            checks++;
            if ({io_addr_strobe, io_write_strobe} !== ((k == 0) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL wr_strobe[%0d] got %b%b", k, io_addr_strobe, io_write_strobe);
            end
            tick();
        end
        io_ready = 1'b0;
        #4;
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL wr_resp got v=%b e=%b d=%h exp 1 0 0", rsp_valid, rsp_err, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        send_cmd(1'b0, 32'hC000_2000, 4'hF, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            #4;
            checks++;
            if ({rsp_valid, busy} !== 2'b01) begin
                errors++;
                $display("FAIL to_wait[%0d] got %b%b exp 01", k, rsp_valid, busy);
            end
        end
        tick();
        #4;
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL to_resp got v=%b e=%b d=%h exp 1 1 ffffffff", rsp_valid, rsp_err,
                     rsp_rdata);
        end
        io_ready = 1'b1;
        io_read_data = 32'h1111_1111;
        tick();
        io_ready = 1'b0;
        #4;
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL to_late_resp got v=%b e=%b d=%h exp 1 1 ffffffff", rsp_valid,
                     rsp_err, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        b_as = n_as;
        io_ready = 1'b1;
        tick();
        io_ready = 1'b0;
        io_read_data = 32'h0;
        #4;
        checks++;
        if ({busy, rsp_valid, io_addr_strobe, rsp_rdata} !== {3'b000, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL to_late_idle got %b%b%b d=%h exp 000 ffffffff", busy, rsp_valid,
                     io_addr_strobe, rsp_rdata);
        end
        checks++;
        if (n_as !== b_as) begin
            errors++;
            $display("FAIL to_late_strobe got %0d exp %0d", n_as, b_as);
        end
    endtask

    task automatic test_back_to_back();
        send_cmd(1'b0, 32'hC000_3000, 4'hF, 32'h0);
        io_ready = 1'b1;
        io_read_data = 32'hCAFE_F00D;
        tick();
        io_ready = 1'b0;
        io_read_data = 32'h0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'hC000_3004;
        cmd_be    = 4'hF;
        cmd_wdata = 32'h55AA_55AA;
        for (int k = 0; k < 10; k++) begin
            #4;
            checks++;
            if ({rsp_valid, cmd_ready, rsp_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b r=%b d=%h", k, rsp_valid, cmd_ready,
                         rsp_rdata);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #4;
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_idle got %b%b exp 10", cmd_ready, rsp_valid);
        end
        tick();
        cmd_valid = 1'b0;
        io_ready = 1'b1;
        #4;
        checks++;
        if ({io_write_strobe, io_address, io_write_data} !==
            {1'b1, 32'hC000_3004, 32'h55AA_55AA}) begin
            errors++;
            $display("FAIL bp_next got %b %h %h", io_write_strobe, io_address, io_write_data);
        end
        tick();
        io_ready = 1'b0;
        #4;
        checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL bp_next_resp got %b %h exp 1 0", rsp_valid, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        send_cmd(1'b0, 32'hC000_4000, 4'hF, 32'h0);
        tick();
        tick();
        #2;
        io_rst = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, busy, io_addr_strobe, rsp_valid, rsp_err} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_ctrl got %b%b%b%b%b exp 00000", cmd_ready, busy,
                     io_addr_strobe, rsp_valid, rsp_err);
        end
        checks++;
        if ({io_address, rsp_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL rstmid_data got %h %h exp 0", io_address, rsp_rdata);
        end
        @(posedge io_clk);
        #3;
        io_rst = 1'b1;
        tick();
        tick();
        #4;
        checks++;
        if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL rstmid_after got %b%b%b exp 001", rsp_valid, busy, cmd_ready);
        end
        send_cmd(1'b0, 32'hC000_5000, 4'hF, 32'h0);
        io_ready = 1'b1;
        io_read_data = 32'h0BAD_BEEF;
        tick();
        io_ready = 1'b0;
        io_read_data = 32'h0;
        #4;
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0BAD_BEEF}) begin
            errors++;
            $display("FAIL rstmid_read got v=%b e=%b d=%h", rsp_valid, rsp_err, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        b_as = n_as;
        send_cmd(1'b0, 32'hC000_0002, 4'hF, 32'h0);
`ifdef IOBUS_INITIATOR_ALIGN_CHECK_EN
        #4;
        checks++;
        if ({rsp_valid, rsp_err, io_addr_strobe, rsp_rdata} !== {3'b110, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL mis_reject got %b%b%b %h", rsp_valid, rsp_err, io_addr_strobe,
                     rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #4;
        checks++;
        if (n_as !== b_as) begin
            errors++;
            $display("FAIL mis_no_strobe got %0d exp %0d", n_as, b_as);
        end
`else
        io_ready = 1'b1;
        io_read_data = 32'h00C0_FFEE;
        #4;
        checks++;
        if ({io_addr_strobe, io_address} !== {1'b1, 32'hC000_0002}) begin
            errors++;
            $display("FAIL mis_strobe got %b %h exp 1 c0000002", io_addr_strobe, io_address);
        end
        tick();
        io_ready = 1'b0;
        #4;
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h00C0_FFEE}) begin
            errors++;
            $display("FAIL mis_resp got v=%b e=%b d=%h", rsp_valid, rsp_err, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #4;
        checks++;
        if (n_as - b_as !== 1) begin
            errors++;
            $display("FAIL mis_strobe_count got %0d exp 1", n_as - b_as);
        end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        cmd_addr     = 32'h0;
        cmd_be       = 4'h0;
        cmd_wdata    = 32'h0;
        rsp_ready    = 1'b0;
        io_read_data = 32'h0;
        io_ready     = 1'b0;
        test_reset();
        test_read_comb();
        test_write_wait();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_misaligned();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
